// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter.
// A start/busy/done handshake runs one iteration per clock. The output
// register holds the last result, so the display never shows partial values.
module bin_to_bcd_seq #(
  parameter int IN_W   = 7,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);
  // Largest value that fits in DIGITS decimal digits.
  localparam longint unsigned MAX_DEC = (longint'(10) ** DIGITS) - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_accept;
  logic              w_last;
  logic              w_busy;
  logic              w_done;
  logic              w_ovf_in;

  logic [IN_W-1:0]   r_shift;
  logic [BCD_W-1:0]  r_scratch;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf_cap;
  logic [BCD_W-1:0]  r_bcd;
  logic              r_ovf;

  logic [BCD_W-1:0]  w_adj;
  logic [BCD_W-1:0]  w_scratch_next;
  logic [IN_W-1:0]   w_shift_next;

  // Overflow is decided from the raw input at capture time.
  assign w_ovf_in = (64'(bin) > MAX_DEC);

  // Add-3 correction: every scratch digit of 5 or more gets +3 before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5)
                              ? (r_scratch[4*gi +: 4] + 4'd3)
                              : r_scratch[4*gi +: 4];
    end
  endgenerate

  // Shift {scratch, shift_reg} left by one; the carry out of the top digit is dropped.
  assign w_scratch_next = BCD_W'({w_adj, r_shift[IN_W-1]});
  assign w_shift_next   = r_shift << 1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_SHIFT;
          w_accept     = 1'b1;
        end
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_state_next = S_DONE;
          w_last       = 1'b1;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Working registers: load on accept, iterate while shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_ovf_cap <= 1'b0;
    end else if (w_accept) begin
      r_shift   <= bin;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_ovf_cap <= w_ovf_in;
    end else if (r_state == S_SHIFT) begin
      r_shift   <= w_shift_next;
      r_scratch <= w_scratch_next;
      r_cnt     <= r_cnt + 1'b1;
    end
  end

  // Result registers change only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd <= '0;
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_bcd <= w_scratch_next;
      r_ovf <= r_ovf_cap;
    end
  end

  assign busy = w_busy;
  assign done = w_done;
  assign bcd  = r_bcd;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: a 3-digit and a 2-digit instance share the
// same stimulus; expected results are queued at start and compared on done.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  bin;
  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          val;
    logic [11:0] bcd3;
    logic        ovf3;
    logic [7:0]  bcd2;
    logic        ovf2;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  logic [12:0] prev3;
  logic [8:0]  prev2;

  bin_to_bcd_seq #(.IN_W(7), .DIGITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy3), .done(done3), .bcd(bcd3), .ovf(ovf3)
  );

  bin_to_bcd_seq #(.IN_W(7), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  // Cycle counter, advanced on every rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Expected result from plain decimal arithmetic.
  task automatic push_exp(input int v, input int due);
    exp_t e;
    e.val  = v;
    e.bcd3 = {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    e.ovf3 = (v > 999);
    e.bcd2 = {4'((v / 10) % 10), 4'(v % 10)};
    e.ovf2 = (v > 99);
    e.due  = due;
    sb_q.push_back(e);
  endtask

  // One-cycle start pulse; the conversion is accepted on the following edge.
  task automatic start_conv(input int v);
    @(negedge clk);
    start = 1'b1;
    bin   = 7'(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    push_exp(v, cyc + 7);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("drain_timeout", sb_q.size(), 0);
  endtask

  // Scoreboard monitor: compares on done, otherwise checks that results hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev3 = {ovf3, bcd3};
      prev2 = {ovf2, bcd2};
    end else if (done3) begin
      if (sb_q.size() == 0) begin
        check_eq("done_unexpected", 32'(done3), 0);
      end else begin
        e = sb_q.pop_front();
        check_eq("latency", cyc, e.due);
        check_eq("done2", 32'(done2), 1);
        check_eq("bcd3", 32'(bcd3), 32'(e.bcd3));
        check_eq("ovf3", 32'(ovf3), 32'(e.ovf3));
        check_eq("bcd2", 32'(bcd2), 32'(e.bcd2));
        check_eq("ovf2", 32'(ovf2), 32'(e.ovf2));
        $display("conv bin=%0d bcd3=%03h ovf3=%0b bcd2=%02h ovf2=%0b", e.val, bcd3, ovf3, bcd2, ovf2);
      end
      prev3 = {ovf3, bcd3};
      prev2 = {ovf2, bcd2};
    end else begin
      check_eq("hold3", 32'({ovf3, bcd3}), 32'(prev3));
      check_eq("hold2", 32'({ovf2, bcd2}), 32'(prev2));
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy3", 32'(busy3), 0);
    check_eq("rst_done3", 32'(done3), 0);
    check_eq("rst_bcd3",  32'(bcd3),  0);
    check_eq("rst_ovf3",  32'(ovf3),  0);
    check_eq("rst_busy2", 32'(busy2), 0);
    check_eq("rst_bcd2",  32'(bcd2),  0);
    @(negedge clk);
    rst_n = 1'b1;

    // 98: busy for exactly 7 sampled cycles, then the done cycle.
    start_conv(98);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check_eq("busy3_on", 32'(busy3), 1);
      check_eq("busy2_on", 32'(busy2), 1);
    end
    @(negedge clk);
    check_eq("busy3_off", 32'(busy3), 0);
    check_eq("done3_on",  32'(done3), 1);
    wait_drain();

    // Zero, the top of the input range, and the 2-digit boundary.
    start_conv(0);
    wait_drain();
    start_conv(127);
    wait_drain();
    start_conv(99);
    wait_drain();
    start_conv(100);
    wait_drain();

    // A second start during SHIFT must be ignored.
    start_conv(45);
    repeat (2) @(negedge clk);
    start = 1'b1;
    bin   = 7'd9;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (12) @(negedge clk);
    check_eq("ignored_start_bcd3", 32'(bcd3), 32'h045);

    // Reset in the middle of a conversion.
    start_conv(63);
    wait_drain();
    start_conv(17);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy3", 32'(busy3), 0);
    check_eq("abort_done3", 32'(done3), 0);
    check_eq("abort_bcd3",  32'(bcd3),  0);
    check_eq("abort_bcd2",  32'(bcd2),  0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check_eq("after_abort_bcd3", 32'(bcd3), 0);

    // Held start: accepted only in IDLE, 9 cycles apart.
    @(negedge clk);
    start = 1'b1;
    bin   = 7'd88;
    @(posedge clk);
    #1;
    push_exp(88, cyc + 7);
    bin = 7'd21;
    repeat (9) @(posedge clk);
    #1;
    push_exp(21, cyc + 7);
    start = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    check_eq("b2b_final_bcd3", 32'(bcd3), 32'h021);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
